// File: rtl/acc_csum_engine.sv
// acc_csum_engine
//   Memory-mapped ones'-complement (Internet) checksum accelerator. Four
//   registers are decoded from io_addr[3:2]: CTRL/STATUS, ADDR, LEN and RESULT.
//   A start streams DATA_WIDTH-bit lines from the packet memory read port.
//   The lanes outside [ADDR, ADDR+LEN) are masked off. Each line is summed as
//   big-endian 16-bit words. The result is folded to a 16-bit
//   non-complemented sum.
//
// Ports
//   clk, rst       : single clock, synchronous active-high reset
//   io_en/io_wen   : IO access strobe / write select
//   io_strb        : write byte enables
//   io_addr        : byte address, bits [3:2] select the register
//   io_wr_data     : write data
//   io_rd_data     : registered read data, 0 when io_rd_valid is low
//   io_rd_valid    : one-cycle pulse, one cycle after a read access
//   acc_en/acc_addr: memory read request (line address)
//   acc_rd_data    : memory read data, valid one cycle after acc_en
//   error          : sticky odd-address error
//   error_ack      : clears error (a simultaneous new error wins)

module acc_csum_engine #(
    parameter int DATA_WIDTH     = 128,
    parameter int STRB_WIDTH     = DATA_WIDTH / 8,
    parameter int ACC_ADDR_WIDTH = 12,
    parameter int LEN_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      io_en,
    input  logic                      io_wen,
    input  logic [3:0]                io_strb,
    input  logic [21:0]               io_addr,
    input  logic [31:0]               io_wr_data,
    output logic [31:0]               io_rd_data,
    output logic                      io_rd_valid,
    output logic                      acc_en,
    output logic [ACC_ADDR_WIDTH-1:0] acc_addr,
    input  logic [DATA_WIDTH-1:0]     acc_rd_data,
    output logic                      error,
    input  logic                      error_ack
);

    localparam int OFF_W  = $clog2(STRB_WIDTH);
    localparam int ADDR_W = ACC_ADDR_WIDTH + OFF_W;
    localparam int WORDS  = STRB_WIDTH / 2;
    localparam int LSUM_W = 16 + $clog2(WORDS);
    localparam int CNT_W  = LEN_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_DRAIN,
        S_FOLD1,
        S_FOLD2
    } state_t;

    state_t                    r_state;
    state_t                    w_state_nxt;

    logic [ADDR_W-1:0]         r_addr;
    logic [LEN_WIDTH-1:0]      r_len;
    logic [15:0]               r_result;
    logic                      r_done;
    logic                      r_error;
    logic [31:0]               r_sum;
    logic [ACC_ADDR_WIDTH-1:0] r_line_addr;
    logic [CNT_W-1:0]          r_lines_left;
    logic                      r_first;
    logic                      r_pipe_valid;
    logic [STRB_WIDTH-1:0]     r_pipe_mask;
    logic [31:0]               r_rd_data;
    logic                      r_rd_valid;

    logic                      w_busy;
    logic                      w_acc_en;
    logic [1:0]                w_sel;
    logic                      w_wr;
    logic                      w_start;
    logic                      w_start_ok;
    logic                      w_odd;
    logic                      w_len_zero;
    logic                      w_err_set;
    logic                      w_last;
    logic [CNT_W-1:0]          w_total;
    logic [CNT_W-1:0]          w_nlines;
    logic [OFF_W-1:0]          w_end_off;
    logic [STRB_WIDTH-1:0]     w_lane_mask;
    logic [DATA_WIDTH-1:0]     w_masked;
    logic [LSUM_W-1:0]         w_line_sum;
    logic [31:0]               w_fold;
    logic [31:0]               w_rd_mux;
    logic                      w_unused;

    // ------------------------------------------------------------------
    // Register access decode
    // ------------------------------------------------------------------
    assign w_sel      = io_addr[3:2];
    assign w_wr       = io_en && io_wen;
    assign w_busy     = (r_state != S_IDLE);
    assign w_start    = w_wr && (w_sel == 2'd0) && io_strb[0] && io_wr_data[0];
    assign w_start_ok = w_start && !w_busy;
    assign w_odd      = r_addr[0];
    assign w_len_zero = (r_len == '0);
    assign w_err_set  = w_start_ok && w_odd;

    // Only io_addr[3:2] and the register-width slices of the write bus matter.
    assign w_unused = ^{io_addr, io_wr_data, io_strb};

    // ------------------------------------------------------------------
    // Line count and last-line boundary.
    // The offset within the first line plus the length gives the span
    // in bytes. That span is rounded up to whole lines.
    // ------------------------------------------------------------------
    assign w_total   = {1'b0, r_len} + CNT_W'(r_addr[OFF_W-1:0]);
    assign w_nlines  = (w_total + CNT_W'(STRB_WIDTH - 1)) >> OFF_W;
    assign w_end_off = w_total[OFF_W-1:0];
    assign w_last    = (r_lines_left == CNT_W'(1));

    // Lane mask for the line being issued this cycle. It travels with the
    // request so that it lines up with the returning data. An end offset
    // of 0 means that the last line is fully used.
    always_comb begin
        w_lane_mask = '0;
        for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
            w_lane_mask[i] = (!r_first || (i >= 32'(r_addr[OFF_W-1:0]))) &&
                             (!w_last || (w_end_off == '0) || (i < 32'(w_end_off)));
        end
    end

    always_comb begin
        w_masked = '0;
        for (int unsigned i = 0; i < STRB_WIDTH; i++) begin
            w_masked[8*i +: 8] = r_pipe_mask[i] ? acc_rd_data[8*i +: 8] : 8'h00;
        end
    end

    // Word k is {lane 2k, lane 2k+1}: the lower address is the MSB.
    always_comb begin
        w_line_sum = '0;
        for (int unsigned k = 0; k < WORDS; k++) begin
            w_line_sum = w_line_sum +
                         LSUM_W'({w_masked[16*k +: 8], w_masked[16*k+8 +: 8]});
        end
    end

    assign w_fold = {16'h0000, r_sum[15:0]} + {16'h0000, r_sum[31:16]};

    always_comb begin
        w_rd_mux = '0;
        case (w_sel)
            2'd0:    w_rd_mux = {29'b0, r_error, r_done, w_busy};
            2'd1:    w_rd_mux = 32'(r_addr);
            2'd2:    w_rd_mux = 32'(r_len);
            default: w_rd_mux = {16'h0000, r_result};
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_acc_en    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok && !w_odd && !w_len_zero) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_acc_en = 1'b1;
                if (w_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: w_state_nxt = S_FOLD1;
            S_FOLD1: w_state_nxt = S_FOLD2;
            S_FOLD2: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers and datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_len        <= '0;
            r_result     <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_sum        <= '0;
            r_line_addr  <= '0;
            r_lines_left <= '0;
            r_first      <= 1'b0;
            r_pipe_valid <= 1'b0;
            r_pipe_mask  <= '0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
        end else begin
            // Reads capture the pre-update register state.
            r_rd_valid <= io_en && !io_wen;
            r_rd_data  <= (io_en && !io_wen) ? w_rd_mux : '0;

            if (w_wr && !w_busy && (w_sel == 2'd1)) begin
                for (int unsigned b = 0; b < ADDR_W; b++) begin
                    if (io_strb[b/8]) begin
                        r_addr[b] <= io_wr_data[b];
                    end
                end
            end
            if (w_wr && !w_busy && (w_sel == 2'd2)) begin
                for (int unsigned b = 0; b < LEN_WIDTH; b++) begin
                    if (io_strb[b/8]) begin
                        r_len[b] <= io_wr_data[b];
                    end
                end
            end

            if (w_err_set) begin
                r_error <= 1'b1;
            end else if (error_ack) begin
                r_error <= 1'b0;
            end

            r_pipe_valid <= w_acc_en;
            r_pipe_mask  <= w_lane_mask;

            if (w_start_ok) begin
                r_result <= '0;
                if (w_odd || w_len_zero) begin
                    r_done <= 1'b1;
                end else begin
                    r_done       <= 1'b0;
                    r_sum        <= '0;
                    r_line_addr  <= r_addr[ADDR_W-1:OFF_W];
                    r_lines_left <= w_nlines;
                    r_first      <= 1'b1;
                end
            end

            if (r_state == S_ISSUE) begin
                r_line_addr  <= r_line_addr + ACC_ADDR_WIDTH'(1);
                r_lines_left <= r_lines_left - CNT_W'(1);
                r_first      <= 1'b0;
            end

            if (r_pipe_valid) begin
                r_sum <= r_sum + 32'(w_line_sum);
            end

            if ((r_state == S_FOLD1) || (r_state == S_FOLD2)) begin
                r_sum <= w_fold;
            end
            if (r_state == S_FOLD2) begin
                r_result <= w_fold[15:0];
                r_done   <= 1'b1;
            end
        end
    end

    assign io_rd_data  = r_rd_data;
    assign io_rd_valid = r_rd_valid;
    assign acc_en      = w_acc_en;
    assign acc_addr    = r_line_addr;
    assign error       = r_error;

endmodule

// File: tb/tb_acc_csum_engine.sv
// tb_acc_csum_engine
//   Directed bench for acc_csum_engine. The bench drives IO accesses and
//   models the packet memory, with a one-cycle read latency. It checks the
//   register readback, the memory request sequence and the timing against
//   hand-computed values.

module tb_acc_csum_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         io_en;
    logic         io_wen;
    logic [3:0]   io_strb;
    logic [21:0]  io_addr;
    logic [31:0]  io_wr_data;
    logic [31:0]  io_rd_data;
    logic         io_rd_valid;
    logic         acc_en;
    logic [11:0]  acc_addr;
    logic [127:0] acc_rd_data;
    logic         error;
    logic         error_ack;

    always #5 clk = ~clk;

    acc_csum_engine #(
        .DATA_WIDTH    (128),
        .STRB_WIDTH    (16),
        .ACC_ADDR_WIDTH(12),
        .LEN_WIDTH     (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .io_en      (io_en),
        .io_wen     (io_wen),
        .io_strb    (io_strb),
        .io_addr    (io_addr),
        .io_wr_data (io_wr_data),
        .io_rd_data (io_rd_data),
        .io_rd_valid(io_rd_valid),
        .acc_en     (acc_en),
        .acc_addr   (acc_addr),
        .acc_rd_data(acc_rd_data),
        .error      (error),
        .error_ack  (error_ack)
    );

    // Packet memory: data returns one cycle after acc_en, garbage otherwise.
    logic [127:0] mem [0:4095];
    always @(posedge clk) begin
        acc_rd_data <= acc_en ? mem[acc_addr] : {4{32'hDEADBEEF}};
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Request monitor
    logic [11:0] en_addrs[$];
    int          en_first;
    int          en_last;
    always @(negedge clk) begin
        if (acc_en) begin
            if (en_addrs.size() == 0) en_first = cyc;
            en_last = cyc;
            en_addrs.push_back(acc_addr);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // All tasks are entered at a falling edge and return at a falling edge.
    task automatic io_write(input logic [1:0] r, input logic [31:0] d);
        io_en      = 1'b1;
        io_wen     = 1'b1;
        io_strb    = 4'hF;
        io_addr    = {18'h2A5, r, 2'b01};
        io_wr_data = d;
        @(negedge clk);
        io_en      = 1'b0;
        io_wen     = 1'b0;
        io_strb    = 4'h0;
        io_wr_data = '0;
    endtask

    task automatic io_read(input logic [1:0] r, output logic [31:0] d);
        io_en   = 1'b1;
        io_wen  = 1'b0;
        io_addr = {18'h15A, r, 2'b10};
        @(negedge clk);
        io_en   = 1'b0;
        check("rd_valid", {31'b0, io_rd_valid}, 32'd1);
        d = io_rd_data;
    endtask

    // Issues a start. On return it is cycle 1 and c1 holds cyc for that cycle.
    task automatic start_run(output int c1);
        en_addrs.delete();
        io_write(2'd0, 32'h1);
        c1 = cyc;
    endtask

    // Starts a run and polls STATUS every cycle. The read issued in cycle
    // k-1 is seen in cycle k.
    task automatic run_and_poll(input int maxc, output int c1, output int done_cyc,
                                output int busy_cnt);
        start_run(c1);
        done_cyc = -1;
        busy_cnt = 0;
        io_en    = 1'b1;
        io_wen   = 1'b0;
        io_addr  = 22'h0;
        for (int k = 2; k <= maxc; k++) begin
            @(negedge clk);
            if (io_rd_valid) begin
                if (io_rd_data[0]) busy_cnt++;
                if (io_rd_data[1] && done_cyc < 0) done_cyc = k - 1;
            end
        end
        io_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic set_byte(input int a, input logic [7:0] b);
        mem[a / 16][8 * (a % 16) +: 8] = b;
    endtask

    logic [7:0] hdr [20] = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00,
                             8'h40, 8'h11, 8'h00, 8'h00, 8'hc0, 8'ha8, 8'h00, 8'h01,
                             8'hc0, 8'ha8, 8'h00, 8'hc7};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        int c1, done_c, busy_c;

        rst        = 1'b1;
        io_en      = 1'b0;
        io_wen     = 1'b0;
        io_strb    = 4'h0;
        io_addr    = '0;
        io_wr_data = '0;
        error_ack  = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("rst_acc_en", {31'b0, acc_en}, 32'd0);
        check("rst_acc_addr", {20'b0, acc_addr}, 32'd0);
        check("rst_rd_valid", {31'b0, io_rd_valid}, 32'd0);
        check("rst_rd_data", io_rd_data, 32'd0);
        check("rst_error", {31'b0, error}, 32'd0);
        io_read(2'd0, d); check("rst_status", d, 32'd0);
        io_read(2'd1, d); check("rst_addr", d, 32'd0);
        io_read(2'd2, d); check("rst_len", d, 32'd0);
        io_read(2'd3, d); check("rst_result", d, 32'd0);

        // IPv4 header at 0x20, 20 bytes
        for (int i = 0; i < 20; i++) set_byte(32'h20 + i, hdr[i]);
        io_write(2'd1, 32'h20);
        io_write(2'd2, 32'd20);
        run_and_poll(10, c1, done_c, busy_c);
        check("ipv4_nreads", en_addrs.size(), 32'd2);
        check("ipv4_first_en", en_first - c1 + 1, 32'd1);
        if (en_addrs.size() >= 2) begin
            check("ipv4_line0", {20'b0, en_addrs[0]}, 32'h2);
            check("ipv4_line1", {20'b0, en_addrs[1]}, 32'h3);
        end
        check("ipv4_done_cycle", done_c, 32'd6);
        check("ipv4_busy_cycles", busy_c, 32'd5);
        io_read(2'd3, d); check("ipv4_result", d, 32'h479E);

        // Unaligned, odd length over all-0xFF lines
        mem[0] = '1;
        mem[1] = '1;
        io_write(2'd1, 32'h0E);
        io_write(2'd2, 32'd3);
        run_and_poll(10, c1, done_c, busy_c);
        check("unal_nreads", en_addrs.size(), 32'd2);
        if (en_addrs.size() >= 2) begin
            check("unal_line0", {20'b0, en_addrs[0]}, 32'h0);
            check("unal_line1", {20'b0, en_addrs[1]}, 32'h1);
        end
        check("unal_done_cycle", done_c, 32'd6);
        io_read(2'd3, d); check("unal_result", d, 32'hFF00);

        // LEN=0: immediate done, RESULT cleared, no reads
        io_write(2'd2, 32'd0);
        run_and_poll(6, c1, done_c, busy_c);
        check("len0_nreads", en_addrs.size(), 32'd0);
        check("len0_done_cycle", done_c, 32'd1);
        check("len0_busy_cycles", busy_c, 32'd0);
        io_read(2'd3, d); check("len0_result", d, 32'd0);
        @(negedge clk);
        check("len0_rd_valid_low", {31'b0, io_rd_valid}, 32'd0);
        check("len0_rd_data_low", io_rd_data, 32'd0);

        // Line address wrap: words 0x1234 (line 0xFFF) and 0x0001 (line 0)
        mem[4095] = 128'h3412;
        mem[0]    = 128'h0100;
        io_write(2'd1, 32'hFFF0);
        io_write(2'd2, 32'd32);
        run_and_poll(10, c1, done_c, busy_c);
        check("wrap_nreads", en_addrs.size(), 32'd2);
        if (en_addrs.size() >= 2) begin
            check("wrap_line0", {20'b0, en_addrs[0]}, 32'hFFF);
            check("wrap_line1", {20'b0, en_addrs[1]}, 32'h000);
        end
        io_read(2'd3, d); check("wrap_result", d, 32'h1235);

        // Odd start address: error, done, no reads
        io_write(2'd1, 32'h11);
        io_write(2'd2, 32'd4);
        start_run(c1);
        io_read(2'd0, d); check("err_status", d, 32'b110);
        check("err_port", {31'b0, error}, 32'd1);
        check("err_nreads", en_addrs.size(), 32'd0);
        io_read(2'd3, d); check("err_result", d, 32'd0);
        error_ack = 1'b1;
        @(negedge clk);
        error_ack = 1'b0;
        check("ack_port", {31'b0, error}, 32'd0);
        io_read(2'd0, d); check("ack_status", d, 32'b010);
        error_ack = 1'b1;
        start_run(c1);
        error_ack = 1'b0;
        check("ack_vs_set_port", {31'b0, error}, 32'd1);
        io_read(2'd0, d); check("ack_vs_set_status", d, 32'b110);

        // Busy protection: LEN=64 over lines of 0x01 bytes
        for (int i = 0; i < 4; i++) mem[i] = {16{8'h01}};
        io_write(2'd1, 32'h0);
        io_write(2'd2, 32'd64);
        start_run(c1);
        io_write(2'd2, 32'd2);
        io_write(2'd0, 32'h1);
        io_write(2'd1, 32'h40);
        repeat (10) @(negedge clk);
        check("busy_nreads", en_addrs.size(), 32'd4);
        check("busy_first_en", en_first - c1 + 1, 32'd1);
        check("busy_last_en", en_last - c1 + 1, 32'd4);
        io_read(2'd3, d); check("busy_result", d, 32'h2020);
        io_read(2'd2, d); check("busy_len_kept", d, 32'd64);
        io_read(2'd1, d); check("busy_addr_kept", d, 32'd0);

        // Reset in cycle 2 of a run, with a read in flight
        io_write(2'd1, 32'h40);
        start_run(c1);
        @(negedge clk);
        rst     = 1'b1;
        io_en   = 1'b1;
        io_wen  = 1'b0;
        io_addr = 22'h0;
        @(negedge clk);
        io_en = 1'b0;
        check("abort_acc_en", {31'b0, acc_en}, 32'd0);
        check("abort_acc_addr", {20'b0, acc_addr}, 32'd0);
        check("abort_rd_valid", {31'b0, io_rd_valid}, 32'd0);
        check("abort_rd_data", io_rd_data, 32'd0);
        check("abort_error", {31'b0, error}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_acc_en", {31'b0, acc_en}, 32'd0);
        io_read(2'd0, d); check("post_rst_status", d, 32'd0);
        io_read(2'd3, d); check("post_rst_result", d, 32'd0);
        io_read(2'd1, d); check("post_rst_addr", d, 32'd0);
        io_read(2'd2, d); check("post_rst_len", d, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
